// File: rtl/traffic_phase_sched_pkg.sv
// Shared definitions for the intersection phase scheduler: phase codes,
// lamp encodings and small decode helpers used by the scheduler.
package traffic_pkg;

   // Phase codes double as the debug "phase" output value.
   typedef enum logic [2:0] {
      MAIN_G  = 3'd0,
      MAIN_Y  = 3'd1,
      AR_M    = 3'd2,
      CROSS_G = 3'd3,
      CROSS_Y = 3'd4,
      AR_C    = 3'd5,
      PED     = 3'd6
   } state_t;

   // One-hot lamp encodings, bit order {R,Y,G}.
   localparam logic [2:0] LIGHT_R = 3'b100;
   localparam logic [2:0] LIGHT_Y = 3'b010;
   localparam logic [2:0] LIGHT_G = 3'b001;

   // Main-road lamp for a given phase; red whenever main does not own the road.
   function automatic logic [2:0] main_light(input state_t s);
      case (s)
         MAIN_G:  return LIGHT_G;
         MAIN_Y:  return LIGHT_Y;
         default: return LIGHT_R;
      endcase
   endfunction

   // Cross-road lamp for a given phase; red whenever cross does not own the road.
   function automatic logic [2:0] cross_light(input state_t s);
      case (s)
         CROSS_G: return LIGHT_G;
         CROSS_Y: return LIGHT_Y;
         default: return LIGHT_R;
      endcase
   endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// Request/lamp bundle between the intersection environment and the scheduler.
// The environment (master) drives the requests; the scheduler (slave) drives
// the lamps, walk signal, acknowledge pulse and debug phase code.
interface traffic_phase_sched_if;

   logic       car_cross;
   logic       ped_req;
   logic [2:0] light_main;
   logic [2:0] light_cross;
   logic       walk;
   logic       ped_ack;
   logic [2:0] phase;

   modport master (
      output car_cross,
      output ped_req,
      input  light_main,
      input  light_cross,
      input  walk,
      input  ped_ack,
      input  phase
   );

   modport slave (
      input  car_cross,
      input  ped_req,
      output light_main,
      output light_cross,
      output walk,
      output ped_ack,
      output phase
   );

endinterface

// File: rtl/traffic_phase_sched_prescaler.sv
// Timing-tick prescaler: counts 0..CLK_DIV-1 and flags the last count as a
// tick. A clear restarts the count so every phase starts on a fresh tick period.
module tick_prescaler #(
   parameter int CLK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = (cnt_q == LAST);

   // Next count: wrap after the tick, restart on a phase change.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/traffic_phase_sched.sv
// Intersection phase scheduler. Main road owns green by default; cross-road
// cars and pedestrians are latched as pending requests and served through
// yellow and all-red clearance phases. Phase lengths are counted in ticks.
module traffic_phase_sched
   import traffic_pkg::*;
#(
   parameter int CLK_DIV   = 50_000_000,
   parameter int TW        = 5,
   parameter int MAIN_MIN  = 10,
   parameter int CROSS_MIN = 5,
   parameter int CROSS_MAX = 15,
   parameter int YEL       = 3,
   parameter int ALLRED    = 1,
   parameter int WALK      = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   traffic_phase_sched_if.slave  bus
);

   // Phase timer compare points: a phase of N ticks expires on the tick seen
   // while the timer still reads N-1.
   localparam logic [TW-1:0] TMAX         = '1;
   localparam logic [TW-1:0] MAIN_MIN_M1  = TW'(MAIN_MIN - 1);
   localparam logic [TW-1:0] CROSS_MIN_M1 = TW'(CROSS_MIN - 1);
   localparam logic [TW-1:0] CROSS_MAX_M1 = TW'(CROSS_MAX - 1);
   localparam logic [TW-1:0] YEL_M1       = TW'(YEL - 1);
   localparam logic [TW-1:0] ALLRED_M1    = TW'(ALLRED - 1);
   localparam logic [TW-1:0] WALK_M1      = TW'(WALK - 1);

   state_t        state_q;
   state_t        state_d;
   logic [TW-1:0] timer_q;
   logic [TW-1:0] timer_d;
   logic          car_pend_q;
   logic          car_pend_d;
   logic          ped_pend_q;
   logic          ped_pend_d;
   logic          ped_ack_q;
   logic          ped_ack_d;

   logic          tick;
   logic          changed;
   logic          car_any;
   logic          ped_any;

   // A request on the deciding cycle itself still counts via the live input.
   assign car_any = car_pend_q | bus.car_cross;
   assign ped_any = ped_pend_q | bus.ped_req;
   assign changed = (state_d != state_q);

   tick_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (changed),
      .tick (tick)
   );

   // Next phase: all transitions are taken on a tick only.
   always_comb begin
      state_d = state_q;
      if (tick) begin
         unique case (state_q)
            MAIN_G: begin
               if ((timer_q >= MAIN_MIN_M1) && (car_any || ped_any)) begin
                  state_d = MAIN_Y;
               end
            end
            MAIN_Y: begin
               if (timer_q == YEL_M1) begin
                  state_d = AR_M;
               end
            end
            AR_M: begin
               // Cars win over pedestrians here; the pedestrian is then served
               // straight after the cross phase, so it waits at most one.
               if (timer_q == ALLRED_M1) begin
                  if (car_any) begin
                     state_d = CROSS_G;
                  end else if (ped_any) begin
                     state_d = PED;
                  end else begin
                     state_d = MAIN_G;
                  end
               end
            end
            CROSS_G: begin
               if ((timer_q == CROSS_MAX_M1) ||
                   ((timer_q >= CROSS_MIN_M1) && !bus.car_cross)) begin
                  state_d = CROSS_Y;
               end
            end
            CROSS_Y: begin
               if (timer_q == YEL_M1) begin
                  state_d = AR_C;
               end
            end
            AR_C: begin
               if (timer_q == ALLRED_M1) begin
                  state_d = ped_any ? PED : MAIN_G;
               end
            end
            PED: begin
               if (timer_q == WALK_M1) begin
                  state_d = MAIN_G;
               end
            end
            default: begin
               state_d = MAIN_G;
            end
         endcase
      end
   end

   // Phase register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= MAIN_G;
      end else begin
         state_q <= state_d;
      end
   end

   // Timer, pending-request latches and acknowledge: next values.
   always_comb begin
      timer_d = timer_q;
      if (changed) begin
         timer_d = '0;
      end else if (tick && (timer_q != TMAX)) begin
         timer_d = timer_q + TW'(1);
      end

      // Cars seen while cross owns the road are served by the running phase.
      car_pend_d = car_pend_q;
      if (bus.car_cross && (state_q != CROSS_G) && (state_q != CROSS_Y)) begin
         car_pend_d = 1'b1;
      end
      if ((state_d == CROSS_G) && (state_q != CROSS_G)) begin
         car_pend_d = 1'b0;
      end

      // Presses during the walk phase are dropped, not queued.
      ped_pend_d = ped_pend_q;
      if (bus.ped_req && (state_q != PED)) begin
         ped_pend_d = 1'b1;
      end
      if ((state_d == PED) && (state_q != PED)) begin
         ped_pend_d = 1'b0;
      end

      ped_ack_d = (state_d == PED) && (state_q != PED);
   end

   // Timer, pending-request latches and acknowledge registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q    <= '0;
         car_pend_q <= 1'b0;
         ped_pend_q <= 1'b0;
         ped_ack_q  <= 1'b0;
      end else begin
         timer_q    <= timer_d;
         car_pend_q <= car_pend_d;
         ped_pend_q <= ped_pend_d;
         ped_ack_q  <= ped_ack_d;
      end
   end

   // Moore output decode straight from the phase register.
   always_comb begin
      bus.light_main  = main_light(state_q);
      bus.light_cross = cross_light(state_q);
      bus.walk        = (state_q == PED);
      bus.ped_ack     = ped_ack_q;
      bus.phase       = state_q;
   end

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Bench for traffic_phase_sched: directed scenarios with hand-derived phase
// lengths, then randomized requests, all cross-checked every cycle against a
// cycle-counting behavioural model of the scheduling rules.
module tb_traffic_phase_sched;

   localparam int CD   = 4;
   localparam int TWP  = 5;
   localparam int MM   = 3;
   localparam int CMIN = 2;
   localparam int CMAX = 4;
   localparam int YL   = 2;
   localparam int AR   = 1;
   localparam int WK   = 3;
   localparam int TSAT = (1 << TWP) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;

   traffic_phase_sched_if bus ();

   traffic_phase_sched #(
      .CLK_DIV   (CD),
      .TW        (TWP),
      .MAIN_MIN  (MM),
      .CROSS_MIN (CMIN),
      .CROSS_MAX (CMAX),
      .YEL       (YL),
      .ALLRED    (AR),
      .WALK      (WK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Model state: phase number, cycles spent in that phase, pending flags.
   int m_ph  = 0;
   int m_cyc = 0;
   bit m_car = 1'b0;
   bit m_ped = 1'b0;
   bit m_ack = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] exp_main(input int ph);
      case (ph)
         0:       return 3'b001;
         1:       return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_cross(input int ph);
      case (ph)
         3:       return 3'b001;
         4:       return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   // Behavioural model: a tick is every CD-th cycle of a phase, the timer is
   // the number of whole tick periods already spent in the phase.
   always @(posedge clk) begin
      int nxt;
      int tmr;
      bit tk;
      bit car;
      bit ped;
      if (rst) begin
         m_ph  <= 0;
         m_cyc <= 0;
         m_car <= 1'b0;
         m_ped <= 1'b0;
         m_ack <= 1'b0;
      end else begin
         tk  = ((m_cyc % CD) == CD - 1);
         tmr = m_cyc / CD;
         if (tmr > TSAT) tmr = TSAT;
         car = m_car | bus.car_cross;
         ped = m_ped | bus.ped_req;
         nxt = m_ph;
         if (tk) begin
            case (m_ph)
               0: if (tmr >= MM - 1 && (car || ped)) nxt = 1;
               1: if (tmr == YL - 1) nxt = 2;
               2: if (tmr == AR - 1) nxt = car ? 3 : (ped ? 6 : 0);
               3: if (tmr == CMAX - 1 || (tmr >= CMIN - 1 && !bus.car_cross)) nxt = 4;
               4: if (tmr == YL - 1) nxt = 5;
               5: if (tmr == AR - 1) nxt = ped ? 6 : 0;
               6: if (tmr == WK - 1) nxt = 0;
               default: nxt = 0;
            endcase
         end
         m_ph  <= nxt;
         m_cyc <= (nxt != m_ph) ? 0 : m_cyc + 1;
         if (nxt == 3 && m_ph != 3)                           m_car <= 1'b0;
         else if (bus.car_cross && m_ph != 3 && m_ph != 4)   m_car <= 1'b1;
         if (nxt == 6 && m_ph != 6)                           m_ped <= 1'b0;
         else if (bus.ped_req && m_ph != 6)                   m_ped <= 1'b1;
         m_ack <= (nxt == 6 && m_ph != 6);
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("phase",       32'(bus.phase),       32'(m_ph));
         chk("light_main",  32'(bus.light_main),  32'(exp_main(m_ph)));
         chk("light_cross", 32'(bus.light_cross), 32'(exp_cross(m_ph)));
         chk("walk",        32'(bus.walk),        32'(m_ph == 6));
         chk("ped_ack",     32'(bus.ped_ack),     32'(m_ack));
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_car();
      bus.car_cross = 1'b1;
      fork
         begin
            @(negedge clk);
            bus.car_cross = 1'b0;
         end
      join_none
   endtask

   task automatic pulse_ped();
      bus.ped_req = 1'b1;
      fork
         begin
            @(negedge clk);
            bus.ped_req = 1'b0;
         end
      join_none
   endtask

   // Counts consecutive cycles in phase ph starting at the current negedge,
   // leaving the caller on the first cycle of the following phase.
   task automatic measure(input int ph, input int exp_len, input int bound, input string nm);
      int n = 0;
      while (bus.phase === 3'(ph) && n < bound) begin
         n++;
         @(negedge clk);
      end
      chk(nm, 32'(n), 32'(exp_len));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      int car_prob;
      bus.car_cross = 1'b0;
      bus.ped_req   = 1'b0;

      // Scenario 1: reset state, then main green holds with no requests.
      do_reset(3);
      chk_en = 1'b1;
      chk("s1_main",  32'(bus.light_main),  32'h1);
      chk("s1_cross", 32'(bus.light_cross), 32'h4);
      chk("s1_walk",  32'(bus.walk),        32'h0);
      chk("s1_ack",   32'(bus.ped_ack),     32'h0);
      chk("s1_phase", 32'(bus.phase),       32'h0);
      measure(0, 200, 200, "s1_main_hold");

      // Scenario 2: single-cycle car pulse right after reset.
      do_reset(3);
      pulse_car();
      measure(0, 12, 40, "s2_main_g");
      measure(1,  8, 30, "s2_main_y");
      measure(2,  4, 30, "s2_ar_m");
      measure(3,  8, 30, "s2_cross_g");
      measure(4,  8, 30, "s2_cross_y");
      measure(5,  4, 30, "s2_ar_c");
      chk("s2_back_main", 32'(bus.phase), 32'h0);

      // Scenario 3: car held high runs cross green to its maximum.
      do_reset(3);
      bus.car_cross = 1'b1;
      measure(0, 12, 40, "s3_main_g");
      measure(1,  8, 30, "s3_main_y");
      measure(2,  4, 30, "s3_ar_m");
      measure(3, 16, 40, "s3_cross_g_max");
      bus.car_cross = 1'b0;
      measure(4,  8, 30, "s3_cross_y");
      measure(5,  4, 30, "s3_ar_c");
      chk("s3_back_main", 32'(bus.phase), 32'h0);

      // Scenario 4: pedestrian only; a press during walk is dropped.
      do_reset(3);
      pulse_ped();
      measure(0, 12, 40, "s4_main_g");
      measure(1,  8, 30, "s4_main_y");
      measure(2,  4, 30, "s4_ar_m");
      chk("s4_ped_phase", 32'(bus.phase),   32'h6);
      chk("s4_ack_entry", 32'(bus.ped_ack), 32'h1);
      pulse_ped();
      n = 0;
      while (bus.walk === 1'b1 && n < 40) begin
         if (n == 1) chk("s4_ack_drop", 32'(bus.ped_ack), 32'h0);
         n++;
         @(negedge clk);
      end
      chk("s4_walk_len", 32'(n), 32'd12);
      chk("s4_back_main", 32'(bus.phase), 32'h0);
      measure(0, 60, 60, "s4_no_second_ped");

      // Scenario 5: car and pedestrian together; pedestrian follows the cross phase.
      do_reset(3);
      pulse_car();
      pulse_ped();
      measure(0, 12, 40, "s5_main_g");
      measure(1,  8, 30, "s5_main_y");
      measure(2,  4, 30, "s5_ar_m");
      measure(3,  8, 30, "s5_cross_g");
      measure(4,  8, 30, "s5_cross_y");
      measure(5,  4, 30, "s5_ar_c");
      chk("s5_ack_entry", 32'(bus.ped_ack),     32'h1);
      chk("s5_ped_main",  32'(bus.light_main),  32'h4);
      chk("s5_ped_cross", 32'(bus.light_cross), 32'h4);
      measure(6, 12, 30, "s5_ped");
      chk("s5_back_main", 32'(bus.phase), 32'h0);
      measure(0, 40, 40, "s5_main_hold");

      // Scenario 6: one-cycle reset in the middle of cross yellow clears pending.
      do_reset(3);
      pulse_car();
      pulse_ped();
      measure(0, 12, 40, "s6_main_g");
      measure(1,  8, 30, "s6_main_y");
      measure(2,  4, 30, "s6_ar_m");
      measure(3,  8, 30, "s6_cross_g");
      repeat (3) @(negedge clk);
      chk("s6_in_cross_y", 32'(bus.phase), 32'h4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("s6_rst_main",  32'(bus.light_main),  32'h1);
      chk("s6_rst_cross", 32'(bus.light_cross), 32'h4);
      chk("s6_rst_phase", 32'(bus.phase),       32'h0);
      chk("s6_rst_walk",  32'(bus.walk),        32'h0);
      measure(0, 100, 100, "s6_pend_cleared");

      // Randomized requests with varying car density and rare resets.
      car_prob = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ((i % 200) == 0) begin
            case ($urandom_range(0, 3))
               0:       car_prob = 0;
               1:       car_prob = 20;
               2:       car_prob = 60;
               default: car_prob = 95;
            endcase
         end
         bus.car_cross = ($urandom_range(0, 99) < car_prob);
         bus.ped_req   = ($urandom_range(0, 99) < 3);
         rst           = ($urandom_range(0, 999) < 2);
      end
      @(negedge clk);
      rst           = 1'b0;
      bus.car_cross = 1'b0;
      bus.ped_req   = 1'b0;
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
